// File: rtl/lsd_pkg.sv
// Shared LSD pipeline constants, width helpers and the gradient pair type.
// Used by grad_2x2 and the downstream angle / region-growing stages.
package lsd_pkg;

    localparam int GRAD_LATENCY = 3;
    localparam int LSD_PIX_W    = 8;

    function automatic int grad_w(input int bitw);
        return bitw + 2;
    endfunction

    function automatic int mag2_w(input int bitw);
        return 2 * bitw + 3;
    endfunction

    typedef struct packed {
        logic signed [grad_w(LSD_PIX_W)-1:0] gx;
        logic signed [grad_w(LSD_PIX_W)-1:0] gy;
    } grad_pair_t;

endpackage

// File: rtl/grad_2x2_line_buf.sv
// One-line buffer: reads the previous row's value and writes the new one at the same address.
// 1-cycle read latency, no backpressure.
module line_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clock,
    input  logic             i_we,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);

    ram_sc #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .FORWARD(0),
        .AW     (AW)
    ) u_ram (
        .clock  (clock),
        .i_we   (i_we),
        .i_waddr(i_addr),
        .i_wdata(i_wdata),
        .i_raddr(i_addr),
        .o_rdata(o_rdata)
    );

endmodule

// File: rtl/ram_sc.sv
// Single-clock RAM, one synchronous read port and one write port; 1-cycle read latency, no backpressure.
// FORWARD=0 returns the old contents on a same-address read/write collision.
module ram_sc #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 8,
    parameter int FORWARD = 0,
    parameter int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clock,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    generate
        if (FORWARD != 0) begin : g_fwd
            logic             r_hit;
            logic [WIDTH-1:0] r_wdata;
            always_ff @(posedge clock) begin
                r_hit   <= i_we && (i_waddr == i_raddr);
                r_wdata <= i_wdata;
            end
            assign o_rdata = r_hit ? r_wdata : r_rdata;
        end else begin : g_nofwd
            assign o_rdata = r_rdata;
        end
    endgenerate

endmodule

// File: rtl/grad_2x2.sv
// LSD 2x2-mask gradient (gx, gy, gx^2+gy^2) with counter pass-through; latency 3, no backpressure.
// Define GRAD_THRESH_EN to zero every pixel whose mag2 <= MAG_THRESH.
module grad_2x2
    import lsd_pkg::*;
#(
    parameter int BIT_WIDTH    = 8,
    parameter int IMAGE_HEIGHT = 8,
    parameter int IMAGE_WIDTH  = 8,
    parameter int FRAME_HEIGHT = 10,
    parameter int FRAME_WIDTH  = 12,
    parameter int MAG_THRESH   = 0
) (
    input  logic                                clock,
    input  logic                                n_rst,
    input  logic [BIT_WIDTH-1:0]                in_pixel,
    input  logic [$clog2(FRAME_HEIGHT)-1:0]     in_vcnt,
    input  logic [$clog2(FRAME_WIDTH)-1:0]      in_hcnt,
    output logic signed [grad_w(BIT_WIDTH)-1:0] out_gx,
    output logic signed [grad_w(BIT_WIDTH)-1:0] out_gy,
    output logic [mag2_w(BIT_WIDTH)-1:0]        out_mag2,
    output logic [$clog2(FRAME_HEIGHT)-1:0]     out_vcnt,
    output logic [$clog2(FRAME_WIDTH)-1:0]      out_hcnt
);

    localparam int GW = grad_w(BIT_WIDTH);
    localparam int MW = mag2_w(BIT_WIDTH);
    localparam int VW = $clog2(FRAME_HEIGHT);
    localparam int HW = $clog2(FRAME_WIDTH);
    localparam int AW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;

    generate
        if (BIT_WIDTH > 14 || MAG_THRESH < 0) begin : g_cfg_check
            $error("grad_2x2: unsupported BIT_WIDTH or MAG_THRESH");
        end
    endgenerate

    logic                 w_active;
    logic                 w_first_col;
    logic                 w_last_col;
    logic                 w_zone;
    logic [BIT_WIDTH-1:0] w_b;

    logic                 r_row_started;
    logic                 r_prev_row_valid;

    assign w_active    = ({1'b0, in_vcnt} < (VW+1)'(IMAGE_HEIGHT)) &&
                         ({1'b0, in_hcnt} < (HW+1)'(IMAGE_WIDTH));
    assign w_first_col = (in_hcnt == '0);
    assign w_last_col  = ({1'b0, in_hcnt} == (HW+1)'(IMAGE_WIDTH - 1));
    // Row 0, column 0 and anything before a fully rewritten row have no valid window.
    assign w_zone      = w_active && (in_vcnt != '0) && (in_hcnt != '0) && r_prev_row_valid;

    line_buf #(
        .WIDTH(BIT_WIDTH),
        .DEPTH(IMAGE_WIDTH),
        .AW   (AW)
    ) u_line_buf (
        .clock  (clock),
        .i_we   (w_active),
        .i_addr (in_hcnt[AW-1:0]),
        .i_wdata(in_pixel),
        .o_rdata(w_b)
    );

    // A row only counts once it has been written from column 0, so a mid-row reset cannot expose stale RAM.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            r_row_started    <= 1'b0;
            r_prev_row_valid <= 1'b0;
        end else if (w_active) begin
            if (w_first_col) begin
                r_row_started <= 1'b1;
            end
            if (w_last_col && r_row_started) begin
                r_prev_row_valid <= 1'b1;
            end
        end
    end

    logic [BIT_WIDTH-1:0] r_a;
    logic [BIT_WIDTH-1:0] r_c;
    logic [BIT_WIDTH-1:0] r_d;
    logic                 r_zone1;

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            r_a     <= '0;
            r_c     <= '0;
            r_d     <= '0;
            r_zone1 <= 1'b0;
        end else begin
            r_d     <= in_pixel;
            r_c     <= r_d;
            r_a     <= w_b;
            r_zone1 <= w_zone;
        end
    end

    logic signed [GW-1:0] w_ax, w_bx, w_cx, w_dx;
    logic signed [GW-1:0] w_gx, w_gy;
    logic signed [GW-1:0] r_gx, r_gy;

    assign w_ax = {2'b00, r_a};
    assign w_bx = {2'b00, w_b};
    assign w_cx = {2'b00, r_c};
    assign w_dx = {2'b00, r_d};
    assign w_gx = (w_bx + w_dx) - (w_ax + w_cx);
    assign w_gy = (w_cx + w_dx) - (w_ax + w_bx);

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            r_gx <= '0;
            r_gy <= '0;
        end else begin
            r_gx <= r_zone1 ? w_gx : '0;
            r_gy <= r_zone1 ? w_gy : '0;
        end
    end

    // |g| < 2^(BIT_WIDTH+1), so each square fits MW-1 bits and the sum fits MW bits.
    logic signed [MW-1:0] w_gxe, w_gye;
    logic signed [MW-1:0] w_sqx, w_sqy;
    logic [MW-1:0]        w_mag2;
    logic                 w_keep;

    assign w_gxe  = {{(MW-GW){r_gx[GW-1]}}, r_gx};
    assign w_gye  = {{(MW-GW){r_gy[GW-1]}}, r_gy};
    assign w_sqx  = w_gxe * w_gxe;
    assign w_sqy  = w_gye * w_gye;
    assign w_mag2 = unsigned'(w_sqx) + unsigned'(w_sqy);

`ifdef GRAD_THRESH_EN
    assign w_keep = ({1'b0, w_mag2} > (MW+1)'(MAG_THRESH));
`else
    assign w_keep = 1'b1;
`endif

    logic [VW-1:0] r_vcnt_p [GRAD_LATENCY];
    logic [HW-1:0] r_hcnt_p [GRAD_LATENCY];

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            out_gx   <= '0;
            out_gy   <= '0;
            out_mag2 <= '0;
            for (int i = 0; i < GRAD_LATENCY; i++) begin
                r_vcnt_p[i] <= '0;
                r_hcnt_p[i] <= '0;
            end
        end else begin
            out_gx      <= w_keep ? r_gx : '0;
            out_gy      <= w_keep ? r_gy : '0;
            out_mag2    <= w_keep ? w_mag2 : '0;
            r_vcnt_p[0] <= in_vcnt;
            r_hcnt_p[0] <= in_hcnt;
            for (int i = 1; i < GRAD_LATENCY; i++) begin
                r_vcnt_p[i] <= r_vcnt_p[i-1];
                r_hcnt_p[i] <= r_hcnt_p[i-1];
            end
        end
    end

    assign out_vcnt = r_vcnt_p[GRAD_LATENCY-1];
    assign out_hcnt = r_hcnt_p[GRAD_LATENCY-1];

endmodule

// File: tb/tb_grad_2x2.sv
// Scoreboard bench for grad_2x2: directed frames, expected results queued at issue, popped by a monitor.
module tb_grad_2x2;

    localparam int BW  = 8;
    localparam int IH  = 8;
    localparam int IW  = 8;
    localparam int FH  = 10;
    localparam int FW  = 12;
    localparam int THR = 400;

    logic              clock    = 1'b0;
    logic              n_rst    = 1'b0;
    logic [BW-1:0]     in_pixel = '0;
    logic [3:0]        in_vcnt  = '0;
    logic [3:0]        in_hcnt  = '0;
    logic signed [9:0] out_gx;
    logic signed [9:0] out_gy;
    logic [18:0]       out_mag2;
    logic [3:0]        out_vcnt;
    logic [3:0]        out_hcnt;

    grad_2x2 #(
        .BIT_WIDTH   (BW),
        .IMAGE_HEIGHT(IH),
        .IMAGE_WIDTH (IW),
        .FRAME_HEIGHT(FH),
        .FRAME_WIDTH (FW),
        .MAG_THRESH  (THR)
    ) dut (
        .clock   (clock),
        .n_rst   (n_rst),
        .in_pixel(in_pixel),
        .in_vcnt (in_vcnt),
        .in_hcnt (in_hcnt),
        .out_gx  (out_gx),
        .out_gy  (out_gy),
        .out_mag2(out_mag2),
        .out_vcnt(out_vcnt),
        .out_hcnt(out_hcnt)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int v;
        int h;
        int gx;
        int gy;
        int mag2;
        int due;
    } exp_t;

    exp_t q[$];
    int   pix[IH][IW];
    bit   m_started = 1'b0;
    bit   m_prv     = 1'b0;

    // Hand-computed values at selected coordinates of the directed frames.
    function automatic void hand(input int fid, input int v, input int h,
                                 output bit hit, output int gx, output int gy, output int m2);
        hit = 1'b1; gx = 0; gy = 0; m2 = 0;
        if      (fid == 0 && v == 4 && h == 4) begin gx = 0;    gy = 0;    m2 = 0;      end
        else if (fid == 1 && v == 3 && h == 3) begin gx = 20;   gy = 0;    m2 = 400;    end
        else if (fid == 2 && v == 4 && h == 5) begin gx = 0;    gy = 510;  m2 = 260100; end
        else if (fid == 3 && v == 3 && h == 3) begin gx = 255;  gy = 255;  m2 = 130050; end
        else if (fid == 3 && v == 3 && h == 4) begin gx = -255; gy = 255;  m2 = 130050; end
        else if (fid == 3 && v == 4 && h == 3) begin gx = 255;  gy = -255; m2 = 130050; end
        else if (fid == 3 && v == 4 && h == 4) begin gx = -255; gy = -255; m2 = 130050; end
        else if (fid == 5 && v == 2 && h == 5) begin gx = 22;   gy = 0;    m2 = 484;    end
        else hit = 1'b0;
    endfunction

    task automatic push_exp(input int fid, input int v, input int h);
        exp_t e;
        bit   active, hit;
        int   a, b, c, d, hgx, hgy, hm2;
        active = (v < IH) && (h < IW);
        e.v = v; e.h = h; e.gx = 0; e.gy = 0; e.mag2 = 0;
        if (active && v > 0 && h > 0 && m_prv) begin
            a = pix[v-1][h-1]; b = pix[v-1][h]; c = pix[v][h-1]; d = pix[v][h];
            e.gx   = (b + d) - (a + c);
            e.gy   = (c + d) - (a + b);
            e.mag2 = e.gx * e.gx + e.gy * e.gy;
            hand(fid, v, h, hit, hgx, hgy, hm2);
            if (hit) begin
                e.gx = hgx; e.gy = hgy; e.mag2 = hm2;
            end
`ifdef GRAD_THRESH_EN
            if (e.mag2 <= THR) begin
                e.gx = 0; e.gy = 0; e.mag2 = 0;
            end
`endif
        end
        e.due = cyc + 3;
        q.push_back(e);
        if (active) begin
            if (h == 0) m_started = 1'b1;
            if (h == IW - 1 && m_started) m_prv = 1'b1;
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        int   agx, agy, am2, av, ah;
        if (q.size() > 0 && q[0].due == cyc) begin
            e   = q.pop_front();
            agx = out_gx; agy = out_gy; am2 = int'(out_mag2);
            av  = int'(out_vcnt); ah = int'(out_hcnt);
            checks++;
            if (agx != e.gx || agy != e.gy || am2 != e.mag2 || av != e.v || ah != e.h) begin
                errors++;
                $display("FAIL out(%0d,%0d): got v=%0d h=%0d gx=%0d gy=%0d mag2=%0d, expected v=%0d h=%0d gx=%0d gy=%0d mag2=%0d",
                         e.v, e.h, av, ah, agx, agy, am2, e.v, e.h, e.gx, e.gy, e.mag2);
            end
        end
    end

    task automatic check_zero(input string name);
        checks++;
        if (out_gx != 0 || out_gy != 0 || out_mag2 != 0 || out_vcnt != 0 || out_hcnt != 0) begin
            errors++;
            $display("FAIL %s: got gx=%0d gy=%0d mag2=%0d v=%0d h=%0d, expected all 0",
                     name, out_gx, out_gy, out_mag2, out_vcnt, out_hcnt);
        end
    endtask

    task automatic fill(input int fid);
        for (int v = 0; v < IH; v++) begin
            for (int h = 0; h < IW; h++) begin
                case (fid)
                    0:       pix[v][h] = 100;
                    1:       pix[v][h] = h * 10;
                    2:       pix[v][h] = (v < 4) ? 0 : 255;
                    3:       pix[v][h] = (v == 3 && h == 3) ? 255 : 0;
                    4:       pix[v][h] = int'($urandom_range(0, 255));
                    default: pix[v][h] = h * 11;
                endcase
            end
        end
    endtask

    task automatic run_frame(input int fid);
        fill(fid);
        for (int v = 0; v < FH; v++) begin
            for (int h = 0; h < FW; h++) begin
                @(negedge clock);
                if (fid == 4 && v == 5 && h == 2) begin
                    #2;
                    n_rst = 1'b0;
                    q.delete();
                    m_started = 1'b0;
                    m_prv     = 1'b0;
                    #1;
                    check_zero("async_reset");
                end
                if (fid == 4 && v == 5 && h == 4) n_rst = 1'b1;
                in_vcnt  = 4'(v);
                in_hcnt  = 4'(h);
                in_pixel = (v < IH && h < IW) ? 8'(pix[v][h]) : 8'hA5;
                if (n_rst) push_exp(fid, v, h);
            end
        end
    endtask

    initial begin
        n_rst = 1'b0;
        repeat (3) @(negedge clock);
        check_zero("reset_state");
        n_rst = 1'b1;
        for (int f = 0; f < 6; f++) run_frame(f);
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clock);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending results, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
